// File: rtl/calc_sequencer.sv
// Calculator entry sequencer with a digit-serial 3-digit BCD add/subtract.
// Strobe-to-register routing is combinational; the result only moves at CALC->SHOW, on clear or on reset.
module calc_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        dig_in,
    input  logic [3:0]  digit,
    input  logic        op_in,
    input  logic        op_sel,
    input  logic        eq_in,
    input  logic        bksp_in,
    input  logic        clr_in,
    input  logic [11:0] opa_bcd,
    input  logic [11:0] opb_bcd,
    output logic        load_A,
    output logic        load_B,
    output logic        bksp_A,
    output logic        bksp_B,
    output logic        clr_regs,
    output logic [11:0] result_bcd,
    output logic        result_neg,
    output logic        overflow,
    output logic [1:0]  display_select,
    output logic        busy
);

    localparam logic [1:0] ST_ENTER_A = 2'd0;
    localparam logic [1:0] ST_ENTER_B = 2'd1;
    localparam logic [1:0] ST_CALC    = 2'd2;
    localparam logic [1:0] ST_SHOW    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        op_q, op_d;
    logic [1:0]  idx_q, idx_d;
    logic [11:0] wa_q, wa_d;
    logic [11:0] wb_q, wb_d;
    logic [11:0] acc_q, acc_d;
    logic        cy_q, cy_d;
    logic        neg_q, neg_d;
    logic [11:0] res_q, res_d;
    logic        rneg_q, rneg_d;
    logic        ovf_q, ovf_d;

    logic act_bksp, act_eq, act_op, act_dig, dig_ok;
    logic ld_a_c, ld_b_c, bk_a_c, bk_b_c, clr_c;
    logic [4:0] d_raw, d_adj;
    logic [3:0] d_out;
    logic       d_cy;

    // One strobe acts per cycle: clr > bksp > eq > op > dig.
    assign act_bksp = bksp_in & ~clr_in;
    assign act_eq   = eq_in & ~clr_in & ~bksp_in;
    assign act_op   = op_in & ~clr_in & ~bksp_in & ~eq_in;
    assign act_dig  = dig_in & ~clr_in & ~bksp_in & ~eq_in & ~op_in;
    assign dig_ok   = (digit <= 4'd9);

    // Working operands shift right one nibble per CALC cycle, so the active digit is always [3:0].
    always_comb begin
        d_raw = 5'd0;
        d_adj = 5'd0;
        d_out = 4'd0;
        d_cy  = 1'b0;
        if (!op_q) begin
            d_raw = {1'b0, wa_q[3:0]} + {1'b0, wb_q[3:0]} + {4'd0, cy_q};
            d_adj = d_raw - 5'd10;
            if (d_raw >= 5'd10) begin
                d_out = d_adj[3:0];
                d_cy  = 1'b1;
            end else begin
                d_out = d_raw[3:0];
            end
        end else begin
            d_raw = {1'b0, wa_q[3:0]} - {1'b0, wb_q[3:0]} - {4'd0, cy_q};
            d_adj = d_raw + 5'd10;
            if (d_raw[4]) begin
                d_out = d_adj[3:0];
                d_cy  = 1'b1;
            end else begin
                d_out = d_raw[3:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wa_d    = wa_q;
        wb_d    = wb_q;
        acc_d   = acc_q;
        cy_d    = cy_q;
        neg_d   = neg_q;
        res_d   = res_q;
        rneg_d  = rneg_q;
        ovf_d   = ovf_q;
        ld_a_c  = 1'b0;
        ld_b_c  = 1'b0;
        bk_a_c  = 1'b0;
        bk_b_c  = 1'b0;
        clr_c   = 1'b0;
        if (clr_in) begin
            clr_c   = 1'b1;
            state_d = ST_ENTER_A;
            res_d   = 12'h000;
            rneg_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ENTER_A: begin
                    if (act_bksp) begin
                        bk_a_c = 1'b1;
                    end else if (act_op) begin
                        op_d    = op_sel;
                        state_d = ST_ENTER_B;
                    end else if (act_dig && dig_ok) begin
                        ld_a_c = 1'b1;
                    end
                end
                ST_ENTER_B: begin
                    if (act_bksp) begin
                        bk_b_c = 1'b1;
                    end else if (act_eq) begin
                        idx_d   = 2'd0;
                        cy_d    = 1'b0;
                        acc_d   = 12'h000;
                        state_d = ST_CALC;
                        // Subtract always runs larger minus smaller and reports the sign separately.
                        if (op_q && (opa_bcd < opb_bcd)) begin
                            wa_d  = opb_bcd;
                            wb_d  = opa_bcd;
                            neg_d = 1'b1;
                        end else begin
                            wa_d  = opa_bcd;
                            wb_d  = opb_bcd;
                            neg_d = 1'b0;
                        end
                    end else if (act_op) begin
                        op_d = op_sel;
                    end else if (act_dig && dig_ok) begin
                        ld_b_c = 1'b1;
                    end
                end
                ST_CALC: begin
                    wa_d  = {4'h0, wa_q[11:4]};
                    wb_d  = {4'h0, wb_q[11:4]};
                    cy_d  = d_cy;
                    acc_d = {d_out, acc_q[11:4]};
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd2) begin
                        state_d = ST_SHOW;
                        res_d   = {d_out, acc_q[11:4]};
                        rneg_d  = neg_q;
                        ovf_d   = ~op_q & d_cy;
                    end
                end
                default: begin
                    if (act_dig) begin
                        clr_c   = 1'b1;
                        state_d = ST_ENTER_A;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ENTER_A;
            op_q    <= 1'b0;
            idx_q   <= 2'd0;
            wa_q    <= 12'h000;
            wb_q    <= 12'h000;
            acc_q   <= 12'h000;
            cy_q    <= 1'b0;
            neg_q   <= 1'b0;
            res_q   <= 12'h000;
            rneg_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wa_q    <= wa_d;
            wb_q    <= wb_d;
            acc_q   <= acc_d;
            cy_q    <= cy_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            rneg_q  <= rneg_d;
            ovf_q   <= ovf_d;
        end
    end

    // Strobe-driven outputs are held low while reset is asserted, independent of the inputs.
    assign load_A         = ld_a_c & reset_n;
    assign load_B         = ld_b_c & reset_n;
    assign bksp_A         = bk_a_c & reset_n;
    assign bksp_B         = bk_b_c & reset_n;
    assign clr_regs       = clr_c & reset_n;
    assign result_bcd     = res_q;
    assign result_neg     = rneg_q;
    assign overflow       = ovf_q;
    assign busy           = (state_q == ST_CALC);
    assign display_select = (state_q == ST_SHOW)    ? 2'd2 :
                            (state_q == ST_ENTER_A) ? 2'd0 : 2'd1;

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized and directed bench for calc_sequencer against an integer-arithmetic calculator model.
module tb_calc_sequencer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        dig_in = 1'b0, op_in = 1'b0, op_sel = 1'b0, eq_in = 1'b0, bksp_in = 1'b0, clr_in = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic [11:0] opa_bcd = 12'h000, opb_bcd = 12'h000;
    logic        load_A, load_B, bksp_A, bksp_B, clr_regs, result_neg, overflow, busy;
    logic [11:0] result_bcd;
    logic [1:0]  display_select;

    calc_sequencer dut (
        .clock(clock), .reset_n(reset_n), .dig_in(dig_in), .digit(digit), .op_in(op_in),
        .op_sel(op_sel), .eq_in(eq_in), .bksp_in(bksp_in), .clr_in(clr_in),
        .opa_bcd(opa_bcd), .opb_bcd(opb_bcd), .load_A(load_A), .load_B(load_B),
        .bksp_A(bksp_A), .bksp_B(bksp_B), .clr_regs(clr_regs), .result_bcd(result_bcd),
        .result_neg(result_neg), .overflow(overflow), .display_select(display_select), .busy(busy)
    );

    always #5 clock = ~clock;

    localparam int M_A = 0, M_B = 1, M_CALC = 2, M_SHOW = 3;

    int n_cmp = 0, n_err = 0;
    int n_la = 0, n_lb = 0, n_busy = 0;
    int m_mode = M_A, m_cnt = 0;
    bit m_op = 1'b0;
    logic [11:0] m_a = 12'h000, m_b = 12'h000, m_res = 12'h000, p_res = 12'h000;
    bit m_neg = 1'b0, m_ovf = 1'b0, p_neg = 1'b0, p_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int b2i(input logic [11:0] x);
        return int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [11:0] i2b(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [1:0] disp_of(input int mode);
        return (mode == M_A) ? 2'd0 : (mode == M_SHOW) ? 2'd2 : 2'd1;
    endfunction

    task automatic model_reset();
        m_mode = M_A; m_cnt = 0; m_op = 1'b0;
        m_a = 12'h000; m_b = 12'h000; m_res = 12'h000; m_neg = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic drive_ops();
        if (m_mode == M_CALC) begin
            opa_bcd = 12'($urandom);
            opb_bcd = 12'($urandom);
        end else begin
            opa_bcd = m_a;
            opb_bcd = m_b;
        end
    endtask

    // One clock cycle: drive strobes, check outputs mid-cycle against the model, then advance the model.
    task automatic cyc(input bit d, input logic [3:0] dg, input bit o, input bit os,
                       input bit e, input bit b, input bit c);
        int act, va, vb;
        dig_in = d; digit = dg; op_in = o; op_sel = os; eq_in = e; bksp_in = b; clr_in = c;
        if (c) act = 1;
        else if (m_mode == M_CALC) act = 0;
        else if (b) act = 2;
        else if (e) act = 3;
        else if (o) act = 4;
        else if (d) act = 5;
        else act = 0;
        @(negedge clock);
        chk("clr_regs", clr_regs, (act == 1) || (act == 5 && m_mode == M_SHOW));
        chk("load_A", load_A, act == 5 && m_mode == M_A && dg <= 9);
        chk("load_B", load_B, act == 5 && m_mode == M_B && dg <= 9);
        chk("bksp_A", bksp_A, act == 2 && m_mode == M_A);
        chk("bksp_B", bksp_B, act == 2 && m_mode == M_B);
        chk("busy", busy, m_mode == M_CALC);
        chk("display_select", display_select, disp_of(m_mode));
        chk("result_bcd", result_bcd, m_res);
        chk("result_neg", result_neg, m_neg);
        chk("overflow", overflow, m_ovf);
        if (load_A) n_la++;
        if (load_B) n_lb++;
        if (busy) n_busy++;
        @(posedge clock);
        #1;
        case (act)
            1: begin
                m_a = 12'h000; m_b = 12'h000; m_res = 12'h000;
                m_neg = 1'b0; m_ovf = 1'b0; m_mode = M_A;
            end
            2: begin
                if (m_mode == M_A) m_a = {4'h0, m_a[11:4]};
                else if (m_mode == M_B) m_b = {4'h0, m_b[11:4]};
            end
            3: if (m_mode == M_B) begin
                va = b2i(m_a); vb = b2i(m_b);
                if (!m_op) begin
                    p_res = i2b((va + vb) % 1000); p_ovf = (va + vb) > 999; p_neg = 1'b0;
                end else begin
                    p_res = i2b(va >= vb ? va - vb : vb - va); p_ovf = 1'b0; p_neg = (va < vb);
                end
                m_mode = M_CALC; m_cnt = 0;
            end
            4: begin
                if (m_mode == M_A) begin m_op = os; m_mode = M_B; end
                else if (m_mode == M_B) m_op = os;
            end
            5: begin
                if (m_mode == M_A && dg <= 9) m_a = {m_a[7:0], dg};
                else if (m_mode == M_B && dg <= 9) m_b = {m_b[7:0], dg};
                else if (m_mode == M_SHOW) begin m_a = 12'h000; m_b = 12'h000; m_mode = M_A; end
            end
            default: if (m_mode == M_CALC) begin
                m_cnt++;
                if (m_cnt == 3) begin
                    m_res = p_res; m_neg = p_neg; m_ovf = p_ovf; m_mode = M_SHOW;
                end
            end
        endcase
        dig_in = 0; digit = 0; op_in = 0; op_sel = 0; eq_in = 0; bksp_in = 0; clr_in = 0;
        drive_ops();
    endtask

    task automatic key(input logic [3:0] k); cyc(1, k, 0, 0, 0, 0, 0); endtask
    task automatic opk(input bit s);         cyc(0, 0, 1, s, 0, 0, 0); endtask
    task automatic eqk();                    cyc(0, 0, 0, 0, 1, 0, 0); endtask
    task automatic idle();                   cyc(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic clrk();                   cyc(0, 0, 0, 0, 0, 0, 1); endtask

    task automatic enter(input logic [11:0] a, input bit s, input logic [11:0] b);
        clrk();
        key(a[11:8]); key(a[7:4]); key(a[3:0]);
        opk(s);
        key(b[11:8]); key(b[7:4]); key(b[3:0]);
    endtask

    task automatic calc(input logic [11:0] a, input bit s, input logic [11:0] b);
        enter(a, s, b);
        eqk(); idle(); idle(); idle();
    endtask

    initial begin
        int la0, lb0, bz0, r;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_result", result_bcd, 12'h000);
        chk("rst_disp", display_select, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {load_A, load_B, bksp_A, bksp_B, clr_regs, result_neg, overflow}, 7'd0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        model_reset(); drive_ops();

        // 123 + 456
        la0 = n_la; lb0 = n_lb;
        enter(12'h123, 1'b0, 12'h456);
        eqk();
        bz0 = n_busy;
        idle(); idle(); idle();
        chk("add_loadA_cnt", n_la - la0, 3);
        chk("add_loadB_cnt", n_lb - lb0, 3);
        chk("add_busy_cycles", n_busy - bz0, 3);
        chk("add_579", result_bcd, 12'h579);
        chk("add_neg", result_neg, 1'b0);
        chk("add_disp", display_select, 2'd2);

        // digit in SHOW discards the key, returns to entry, keeps the result
        key(4'd7);
        chk("show_dig_disp", display_select, 2'd0);
        chk("show_dig_keep", result_bcd, 12'h579);

        calc(12'h900, 1'b0, 12'h200);
        chk("ovf_res", result_bcd, 12'h100);
        chk("ovf_flag", overflow, 1'b1);
        calc(12'h045, 1'b1, 12'h120);
        chk("sub_res", result_bcd, 12'h075);
        chk("sub_neg", result_neg, 1'b1);
        calc(12'h300, 1'b1, 12'h300);
        chk("sub_eq_res", result_bcd, 12'h000);
        chk("sub_eq_neg", result_neg, 1'b0);

        // CALC lockout at E+1, abort with clr at E+2
        enter(12'h123, 1'b0, 12'h004);
        eqk();
        cyc(1, 4'd5, 1, 1, 0, 1, 0);
        la0 = n_la;
        clrk();
        chk("abort_disp", display_select, 2'd0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_res", result_bcd, 12'h000);
        key(4'd8); idle(); idle(); idle();
        chk("abort_loadA", n_la - la0, 1);
        chk("abort_no_show", display_select, 2'd0);

        // priority and routing
        cyc(1, 4'd3, 0, 0, 0, 0, 1);
        key(4'd12);
        key(4'd1); opk(1'b0);
        cyc(1, 4'd2, 0, 0, 0, 1, 0);
        key(4'd12);
        cyc(1, 4'd2, 1, 0, 1, 0, 0);

        // asynchronous reset mid-CALC
        enter(12'h222, 1'b0, 12'h333);
        eqk(); idle(); idle();
        dig_in = 1'b1; digit = 4'd4; reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_disp", display_select, 2'd0);
        chk("arst_res", result_bcd, 12'h000);
        chk("arst_strobes", {load_A, load_B, clr_regs, result_neg, overflow}, 5'd0);
        @(negedge clock) begin reset_n = 1'b1; dig_in = 1'b0; digit = 4'd0; end
        @(posedge clock); #1;
        model_reset(); drive_ops();
        la0 = n_la;
        key(4'd5);
        chk("arst_resume_loadA", n_la - la0, 1);

        // random single-strobe traffic, occasional clr/dig collisions
        repeat (600) begin
            r = $urandom_range(0, 23);
            if (r == 0)       cyc($urandom_range(0, 1) == 1, 4'($urandom_range(0, 9)), 0, 0, 0, 0, 1);
            else if (r <= 2)  cyc(0, 0, 0, 0, 0, 1, 0);
            else if (r <= 5)  eqk();
            else if (r <= 7)  opk($urandom_range(0, 1) == 1);
            else if (r <= 17) key(4'($urandom_range(0, 11)));
            else              idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Calculator sequencer. Routes debounced keypad and pushbutton strobes to the A/B operand registers and runs a digit-serial BCD add/subtract over their 3-digit contents. Drives the display mux select and holds the signed result until the next entry. Sits between the key-strobe generators and the operand registers and display mux, in place of the plain entry FSM.

## Interface
- No parameters. Operand width is fixed at 3 BCD digits (12 bits).
- clock  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- dig_in  in  1  one-cycle digit-key strobe
- digit  in  4  key code, valid with dig_in; only values 0-9 are digits
- op_in  in  1  one-cycle operator strobe
- op_sel  in  1  operator, valid with op_in: 0 = add, 1 = subtract
- eq_in  in  1  one-cycle equals strobe
- bksp_in  in  1  one-cycle backspace strobe
- clr_in  in  1  one-cycle clear strobe
- opa_bcd  in  12  operand A register contents, digit 2 in [11:8]
- opb_bcd  in  12  operand B register contents
- load_A, load_B  out  1  shift digit into A / B register (combinational, same cycle as dig_in)
- bksp_A, bksp_B  out  1  backspace A / B register (combinational)
- clr_regs  out  1  clear both operand registers (combinational)
- result_bcd  out  12  result magnitude, registered
- result_neg  out  1  result is negative
- overflow  out  1  sum exceeded 999
- display_select  out  2  0 = A, 1 = B, 2 = result; 3 never driven
- busy  out  1  high while computing

## Operation
- States: ENTER_A, ENTER_B, CALC (3-cycle digit counter, idx 0..2), SHOW.
- Priority when strobes coincide: clr > bksp > eq > op > dig. Exactly one strobe acts per cycle.
- clr_in, any state including CALC:
  - pulse clr_regs
  - go to ENTER_A
  - clear result_bcd, result_neg and overflow; display_select = 0
- ENTER_A:
  - dig_in with digit ≤ 9 → load_A
  - digit > 9 → ignored
  - bksp_in → bksp_A
  - op_in → latch op_sel, go to ENTER_B
  - eq_in → ignored
- ENTER_B:
  - dig_in → load_B
  - bksp_in → bksp_B
  - op_in → relatch op_sel only
  - eq_in → capture opa_bcd/opb_bcd into working registers, go to CALC with idx = 0
- CALC: every strobe except clr is ignored. One digit per cycle, LSD first.
  - Add: digit = a + b + carry. If ≥ 10, subtract 10 and set carry. Carry out of idx 2 sets overflow; result keeps the low 3 digits.
  - Subtract: at capture, minuend = larger of A and B (packed BCD compared as unsigned binary), subtrahend = the smaller. result_neg = (A < B). Per digit, m − s − borrow; if negative, add 10 and set borrow. A = B gives 000 with neg 0.
  - Operand nibbles > 9 give an unspecified result; no check is made.
- SHOW:
  - dig_in → pulse clr_regs, go to ENTER_A. The digit is discarded; result is kept until the next eq.
  - bksp_in, op_in, eq_in → ignored
- display_select = 0 in ENTER_A, 1 in ENTER_B and CALC, 2 in SHOW.

## Timing
- Reset values: state ENTER_A, result_bcd 000, result_neg 0, overflow 0, display_select 0, busy 0, op latch 0, all strobe outputs 0.
- reset_n low at any time, including mid-CALC, forces reset values immediately.
- load/bksp/clr_regs outputs are Mealy outputs, asserted in the same cycle as the causing strobe and never longer.
- eq_in sampled at edge E:
  - CALC covers idx 0, 1, 2 at edges E+1, E+2, E+3.
  - At E+3: state becomes SHOW; result_bcd, result_neg and overflow update together; display_select = 2.
  - busy is high from after E until after E+3 (3 cycles).
- Result outputs change only at the CALC→SHOW edge, on clr, or on reset. Partial digits are held in a working register and are never visible.
- Operand inputs are don't-care after edge E.

## Test plan
- Add 123 + 456: strobe digits 1,2,3 in ENTER_A, op add, digits 4,5,6, eq.
  - Exactly 3 load_A and 3 load_B pulses.
  - busy for 3 cycles.
  - At E+3: result 579, neg 0, ovf 0, display_select 2.
- Add with overflow, 900 + 200 → result 100, overflow 1, neg 0.
- Subtract, A < B, 045 − 120 → result 075, result_neg 1; 300 − 300 → 000, neg 0.
- CALC lockout and abort:
  - dig/op/bksp at E+1 produce no pulses and no state change.
  - clr_in at E+2 → clr_regs pulse, result 000, display_select 0, busy 0; subsequent digits load A.
- Priority and routing:
  - clr_in with dig_in in ENTER_A → clr_regs only, no load_A.
  - bksp_in in ENTER_B → bksp_B only.
  - digit 12 with dig_in → no load.
  - dig_in in SHOW → clr_regs, state ENTER_A.
- Drop reset_n at E+2 → all outputs at reset values without waiting for a clock edge; after release, normal entry resumes in ENTER_A.
